regfile_scb: RTL
================

REGFILE_SCB -- requirements
Module: regfile_scb

Interface
REQ-001 Parameter DATA_W, default 32: register width in bits.
REQ-002 Parameter ADDR_W, default 5: address width; DEPTH = 2**ADDR_W entries.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 readReg1  input  ADDR_W  read port 1 address.
REQ-006 readReg2  input  ADDR_W  read port 2 address.
REQ-007 readData1  output  DATA_W  read port 1 data.
REQ-008 readData2  output  DATA_W  read port 2 data.
REQ-009 RegWrite  input  1  write enable.
REQ-010 writeReg  input  ADDR_W  write address.
REQ-011 writeData  input  DATA_W  write data.
REQ-012 rsvEn  input  1  scoreboard reservation request.
REQ-013 rsvReg  input  ADDR_W  register to mark pending.
REQ-014 busy1  output  1  readReg1 has a pending write.
REQ-015 busy2  output  1  readReg2 has a pending write.
REQ-016 ready  output  1  clear sweep done; accesses accepted.

Function
REQ-017 Storage SHALL be DEPTH x DATA_W with at most one write per cycle, so the storage maps onto inferred RAM.
REQ-018 The FSM SHALL have two states, CLEAR and READY; ready SHALL be 1 only in READY.
REQ-019 In CLEAR, one entry per cycle SHALL be written to 0 at clear pointer ptr, and ptr SHALL increment; the edge that clears entry DEPTH-1 SHALL move the FSM to READY.
REQ-020 ready SHALL rise exactly DEPTH cycles after the first rising edge with rst low (32 cycles at default).
REQ-021 While not ready, RegWrite and rsvEn SHALL be ignored, and readData1/2 and busy1/2 SHALL read 0.
REQ-022 Reads SHALL be combinational: readDataN = entry[readRegN].
REQ-023 Address 0 SHALL always read 0 and never report busy; writes and reservations to address 0 SHALL be ignored.
REQ-024 In READY, RegWrite with writeReg!=0 SHALL update entry[writeReg] at the clock edge.
REQ-025 The scoreboard SHALL hold one busy bit per entry; rsvEn in READY with rsvReg!=0 SHALL set busy[rsvReg] at the edge.
REQ-026 RegWrite in READY SHALL clear busy[writeReg] at the edge.
REQ-027 When a set and a clear target the same address in the same cycle, the set SHALL win; different addresses SHALL update independently.
REQ-028 busyN SHALL be the combinational value busy[readRegN], reflecting the current registered state with no bypass.
REQ-029 Reserving an already-busy entry SHALL leave it busy; a write to a non-busy entry SHALL be legal and leave it not busy.

Reset
REQ-030 rst high at an edge SHALL set state=CLEAR, ptr=0 and all busy bits=0; ready=0 from that edge onward.
REQ-031 rst asserted mid-sweep or in READY SHALL restart the sweep at ptr=0, with full DEPTH-cycle latency.
REQ-032 While rst is high, no entry SHALL be written and the sweep SHALL not advance.

Configuration
REQ-033 Macro REGFILE_BYPASS_EN defined: in READY, when RegWrite=1, writeReg!=0 and writeReg==readRegN, readDataN SHALL equal writeData in the same cycle.
REQ-034 REGFILE_BYPASS_EN undefined: readDataN SHALL return the stored (pre-write) value until the edge after the write.

Verification
REQ-035 Assert rst 1 cycle, release -> ready=0 for 32 cycles then 1; every readReg 0..31 reads 0x00000000.
REQ-036 Write 0xDEADBEEF to r5, next cycle readReg1=5 -> 0xDEADBEEF; write 0x1234 to r0 -> readReg2=0 reads 0.
REQ-037 Same cycle RegWrite r7=0xA5A5A5A5 with readReg1=7 -> 0xA5A5A5A5 with REGFILE_BYPASS_EN; prior value (0) without.
REQ-038 rsvEn r9 -> next cycle busy1=1 (readReg1=9); write r9 -> next cycle busy1=0; rsvEn r9 plus RegWrite r9 same cycle -> busy stays 1.
REQ-039 Write r3=0x55 while ready, pulse rst at sweep cycle 10 -> ready low 32 cycles from release, r3 reads 0, all busy 0.
REQ-040 RegWrite/rsvEn on r4 during CLEAR -> ignored: r4 reads 0 and busy 0 after ready.

Source files
------------

// File: rtl/regfile_scb.sv
// regfile_scb: register file with clear sweep after reset and pending-write scoreboard; define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding
module regfile_scb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] writeReg,
  input  logic [DATA_W-1:0] writeData,
  input  logic              rsvEn,
  input  logic [ADDR_W-1:0] rsvReg,
  output logic              busy1,
  output logic              busy2,
  output logic              ready
);
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic {CLEAR, READY} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic wr_ok, rsv_ok, we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  assign ready  = state == READY;
  assign wr_ok  = ready && RegWrite && writeReg != '0;
  assign rsv_ok = ready && rsvEn && rsvReg != '0;
  assign we     = !rst && (!ready || wr_ok);
  assign wa     = ready ? writeReg : ptr;
  assign wd     = ready ? writeData : '0;
  // sweep finishes on the edge that clears the last entry
  always_comb begin
    state_nx = state;
    if (state == CLEAR && ptr == {ADDR_W{1'b1}}) state_nx = READY;
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR;
    else state <= state_nx;
  end
  // clear pointer advances one entry per cycle while sweeping
  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else if (!ready) ptr <= ptr + 1'b1;
  end
  // single write port shared by the sweep and normal writes, no reset so it maps to RAM
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end
  // scoreboard: the set is applied last so a same-address reservation wins over a clear
  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else begin
      if (wr_ok) busy[writeReg] <= 1'b0;
      if (rsv_ok) busy[rsvReg] <= 1'b1;
    end
  end
`ifdef REGFILE_BYPASS_EN
  assign readData1 = (!ready || readReg1 == '0) ? '0 : (wr_ok && writeReg == readReg1) ? writeData : mem[readReg1];
  assign readData2 = (!ready || readReg2 == '0) ? '0 : (wr_ok && writeReg == readReg2) ? writeData : mem[readReg2];
`else
  assign readData1 = (!ready || readReg1 == '0) ? '0 : mem[readReg1];
  assign readData2 = (!ready || readReg2 == '0) ? '0 : mem[readReg2];
`endif
  assign busy1 = ready && readReg1 != '0 && busy[readReg1];
  assign busy2 = ready && readReg2 != '0 && busy[readReg2];
endmodule
